// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: merges N requester ports onto one registered bus-master port,
// with round-robin or fixed-priority grant and an optional ack timeout that flags an error.
module bus_master_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ARB_RR  = 1,
    parameter int TIMEOUT = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_PORTS-1:0]            i_req,
    input  logic [N_PORTS-1:0]            i_wr_en,
    input  logic [N_PORTS*ADDR_W-1:0]     i_addr,
    input  logic [N_PORTS*DATA_W-1:0]     i_wr_data,
    input  logic [N_PORTS*DATA_W/8-1:0]   i_byte_en,
    output logic [N_PORTS-1:0]            o_ready,
    output logic [N_PORTS-1:0]            o_err,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_bus_en,
    output logic                          o_wr_en,
    output logic [ADDR_W-1:0]             o_addr,
    output logic [DATA_W-1:0]             o_wr_data,
    output logic [DATA_W/8-1:0]           o_byte_en,
    input  logic                          i_ack,
    input  logic [DATA_W-1:0]             i_rd_data
);
    localparam int BE_W = DATA_W / 8;
    localparam int GW   = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
    localparam int CW   = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state;
    logic [GW-1:0]   ptr, grant, pick;
    logic [CW-1:0]   cnt;
    logic            hit, timed_out;

    // Search starts at the rotating pointer in round-robin mode, at port 0 otherwise.
    always_comb begin
        int k;
        pick = '0;
        hit  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            k = ARB_RR != 0 ? int'(ptr) + i : i;
            if (k >= N_PORTS) k = k - N_PORTS;
            if (!hit && i_req[k]) begin
                hit  = 1'b1;
                pick = GW'(k);
            end
        end
    end

    assign timed_out = (TIMEOUT > 0) && (cnt == TC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            cnt       <= '0;
            o_ready   <= '0;
            o_err     <= '0;
            o_rd_data <= '0;
            o_bus_en  <= 1'b0;
            o_wr_en   <= 1'b0;
            o_addr    <= '0;
            o_wr_data <= '0;
            o_byte_en <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_ready <= '0;
                    o_err   <= '0;
                    if (hit) begin
                        state     <= BUS;
                        grant     <= pick;
                        cnt       <= '0;
                        o_bus_en  <= 1'b1;
                        o_wr_en   <= i_wr_en[pick];
                        o_addr    <= i_addr[pick*ADDR_W +: ADDR_W];
                        o_wr_data <= i_wr_data[pick*DATA_W +: DATA_W];
                        o_byte_en <= i_byte_en[pick*BE_W +: BE_W];
                        if (ARB_RR != 0) ptr <= int'(pick) == N_PORTS - 1 ? '0 : pick + 1'b1;
                    end
                end
                BUS: begin
                    // Ack takes precedence over a coincident terminal count.
                    if (i_ack || timed_out) begin
                        state     <= RESP;
                        o_bus_en  <= 1'b0;
                        o_ready   <= N_PORTS'(1) << grant;
                        o_err     <= {N_PORTS{~i_ack}} & (N_PORTS'(1) << grant);
                        o_rd_data <= i_ack ? i_rd_data : '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= '0;
                    o_err   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: directed vectors for a 4-port round-robin arbiter with TIMEOUT=8,
// plus a fixed-priority twin that is acked as soon as it drives the bus.
module tb_bus_master_arbiter;
    localparam int N = 4, AW = 32, DW = 32, BW = 4;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]    req = '0, wr = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N*BW-1:0] be = '0;
    logic            ack = 1'b0;
    logic [DW-1:0]   rdata = '0;

    logic [N-1:0]    ready, err, fp_ready, fp_err;
    logic [DW-1:0]   rd, bwdata, fp_rd, fp_wdata;
    logic [AW-1:0]   baddr, fp_addr;
    logic [BW-1:0]   bbe, fp_be;
    logic            bus_en, bwr, fp_bus_en, fp_wr, fp_ack;

    assign fp_ack = fp_bus_en;

    bus_master_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(1), .TIMEOUT(8)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr_en(wr), .i_addr(addr),
        .i_wr_data(wdata), .i_byte_en(be), .o_ready(ready), .o_err(err), .o_rd_data(rd),
        .o_bus_en(bus_en), .o_wr_en(bwr), .o_addr(baddr), .o_wr_data(bwdata),
        .o_byte_en(bbe), .i_ack(ack), .i_rd_data(rdata));

    bus_master_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(0), .TIMEOUT(0)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr_en(wr), .i_addr(addr),
        .i_wr_data(wdata), .i_byte_en(be), .o_ready(fp_ready), .o_err(fp_err), .o_rd_data(fp_rd),
        .o_bus_en(fp_bus_en), .o_wr_en(fp_wr), .o_addr(fp_addr), .o_wr_data(fp_wdata),
        .o_byte_en(fp_be), .i_ack(fp_ack), .i_rd_data(rdata));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    typedef struct {
        int          port;
        logic        w;
        logic [31:0] a, d;
        logic [3:0]  b;
        int          delay;
        logic [31:0] bus_rd;
        logic [3:0]  e_ready;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_cycles;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_port(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
        wr[k] = w;
        addr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
        be[k*BW +: BW] = b;
    endtask

    task automatic do_reset();
        req = '0;
        ack = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic int idx(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    initial begin
        int c;
        int g_rr[$], g_fp[$], t_rr[$];
        tbl[0] = '{1, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 4'b0010, 1'b0, 32'hDEAD_BEEF, 2};
        tbl[1] = '{0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 5, 32'hCAFE_0000, 4'b0001, 1'b0, 32'hCAFE_0000, 5};
        tbl[2] = '{3, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'h5555_AAAA, 4'b1000, 1'b1, 32'h0, 8};
        tbl[3] = '{2, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 8, 32'h0000_0077, 4'b0100, 1'b0, 32'h0000_0077, 8};
        tbl[4] = '{3, 1'b1, 32'h0000_0FFC, 32'hA5A5_5A5A, 4'b1100, 1, 32'h0000_0011, 4'b1000, 1'b0, 32'h0000_0011, 1};

        // Reset state, then an asynchronous reset that kills a transaction mid-bus.
        do_reset();
        check("rst_ready", ready, 0);
        check("rst_err", err, 0);
        check("rst_bus_en", bus_en, 0);
        check("rst_rd", rd, 0);
        check("rst_addr", baddr, 0);
        set_port(0, 1'b1, 32'h100, 32'hAAAA, 4'hF);
        req = 4'b0001;
        step();
        check("pre_rst_bus_en", bus_en, 1);
        check("pre_rst_addr", baddr, 32'h100);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bus_en", bus_en, 0);
        check("async_rst_ready", ready, 0);
        check("async_rst_addr", baddr, 0);
        req = '0;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            check("post_rst_bus_en", bus_en, 0);
            check("post_rst_ready", ready, 0);
        end

        // Single transactions: bus fields must hold while every requester input is scrambled.
        for (int v = 0; v < 5; v++) begin
            set_port(tbl[v].port, tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].b);
            req = N'(1) << tbl[v].port;
            rdata = tbl[v].bus_rd;
            step();
            check("grant_bus_en", bus_en, 1);
            req = '0;
            c = 0;
            while (ready == 0 && c < 12) begin
                c++;
                check("hold_bus_en", bus_en, 1);
                check("hold_addr", baddr, tbl[v].a);
                check("hold_wdata", bwdata, tbl[v].d);
                check("hold_be", bbe, tbl[v].b);
                check("hold_wr", bwr, tbl[v].w);
                ack = (c == tbl[v].delay);
                addr = {$urandom(), $urandom(), $urandom(), $urandom()};
                wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                be = 16'($urandom());
                wr = ~wr;
                step();
            end
            ack = 1'b0;
            check("bus_cycles", c, tbl[v].e_cycles);
            check("ready", ready, tbl[v].e_ready);
            check("err", err, {3'b0, tbl[v].e_err} << tbl[v].port);
            check("rd_data", rd, tbl[v].e_rd);
            check("resp_bus_en", bus_en, 0);
            step();
            check("ready_one_cycle", ready, 0);
            check("idle_bus_en", bus_en, 0);
        end

        // All ports requesting with immediate ack: round-robin rotates, fixed priority sticks at 0.
        do_reset();
        req = 4'hF;
        ack = 1'b1;
        for (int cy = 0; cy < 40 && (g_rr.size() < 5 || g_fp.size() < 4); cy++) begin
            step();
            if (ready != 0) begin
                check("rr_onehot", $countones(ready), 1);
                g_rr.push_back(idx(ready));
                t_rr.push_back(cy);
            end
            if (fp_ready != 0) g_fp.push_back(idx(fp_ready));
        end
        req = '0;
        ack = 1'b0;
        for (int i = 0; i < 5; i++) check("rr_grant", i < g_rr.size() ? g_rr[i] : -1, i % 4);
        for (int i = 0; i < 4; i++) check("fp_grant", i < g_fp.size() ? g_fp[i] : -1, 0);
        for (int i = 1; i < 5; i++) check("rr_spacing", i < t_rr.size() ? t_rr[i] - t_rr[i-1] : -1, 3);

        // Stray ack in IDLE, then pointer wrap from 3 back to 0.
        do_reset();
        ack = 1'b1;
        repeat (2) begin
            step();
            check("stray_ack_bus_en", bus_en, 0);
            check("stray_ack_ready", ready, 0);
        end
        ack = 1'b0;
        set_port(1, 1'b0, 32'h10, 32'h0, 4'hF);
        set_port(0, 1'b0, 32'hA0, 32'h0, 4'hF);
        set_port(2, 1'b0, 32'hA2, 32'h0, 4'hF);
        req = 4'b0010;
        step();
        req = '0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("wrap_setup_ready", ready, 4'b0010);
        step();
        req = 4'b0101;
        step();
        check("wrap_first_addr", baddr, 32'hA2);
        req = 4'b0001;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("wrap_first_ready", ready, 4'b0100);
        step();
        step();
        check("wrap_second_addr", baddr, 32'hA0);
        req = '0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("wrap_second_ready", ready, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
